// File: rtl/mult_datapath.sv
// Datapath for the shift-and-add multiplier. It holds the accumulator/multiplier
// shift register, the multiplicand, the bit counter and the registered product.
module mult_datapath #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = $clog2(N)
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Load,
    input  logic            Ad,
    input  logic            Sh,
    input  logic            Done,
    input  logic [N-1:0]    Mcand,
    input  logic [N-1:0]    Mplier,
    output logic            M,
    output logic            K,
    output logic [2*N-1:0]  Product,
    output logic            Valid
);

    localparam int unsigned AW = 2*N + 1;
    localparam int unsigned PW = 2*N;

    logic [AW-1:0] acc_q, acc_d;
    logic [N-1:0]  mc_q, mc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] product_q, product_d;
    logic          valid_q, valid_d;
    logic [N:0]    sum;
    logic          last_c;

    // Upper half plus multiplicand; the carry lands in bit N of the sum.
    assign sum    = {1'b0, acc_q[PW-1:N]} + {1'b0, mc_q};
    assign last_c = (cnt_q == CW'(N-1));

    always_comb begin
        acc_d     = acc_q;
        mc_d      = mc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        valid_d   = valid_q;

        if (Load) begin
            acc_d = {(N+1)'(0), Mplier};
            mc_d  = Mcand;
            cnt_d = '0;
        end else begin
            if (Ad && Sh) begin
                acc_d = {1'b0, sum, acc_q[N-1:1]};
            end else if (Ad) begin
                acc_d = {sum, acc_q[N-1:0]};
            end else if (Sh) begin
                acc_d = {1'b0, acc_q[AW-1:1]};
            end
            if (Sh) begin
                cnt_d = last_c ? '0 : cnt_q + CW'(1);
            end
        end

        // Done captures the pre-edge accumulator; a concurrent Load still clears Valid.
        if (Done) begin
            product_d = acc_q[PW-1:0];
        end
        if (Load) begin
            valid_d = 1'b0;
        end else if (Done) begin
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc_q     <= '0;
            mc_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            mc_q      <= mc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            valid_q   <= valid_d;
        end
    end

    assign M       = acc_q[0];
    assign K       = last_c;
    assign Product = product_q;
    assign Valid   = valid_q;

endmodule

// File: tb/tb_mult_datapath.sv
// Directed bench for mult_datapath (N=4): full multiplies, strobe priority,
// asynchronous reset and product hold behaviour.
module tb_mult_datapath;

    localparam int unsigned N = 4;

    logic         Clk;
    logic         Rst_n;
    logic         Load, Ad, Sh, Done;
    logic [N-1:0] Mcand, Mplier;
    logic         M, K;
    logic [2*N-1:0] Product;
    logic         Valid;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [2*N:0] acc_m;
    logic         carry_seen;

    mult_datapath #(.N(N)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Load    (Load),
        .Ad      (Ad),
        .Sh      (Sh),
        .Done    (Done),
        .Mcand   (Mcand),
        .Mplier  (Mplier),
        .M       (M),
        .K       (K),
        .Product (Product),
        .Valid   (Valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, sample 1 time unit later, then drop all strobes.
    task automatic tick();
        @(posedge Clk);
        #1;
        Load = 1'b0;
        Ad   = 1'b0;
        Sh   = 1'b0;
        Done = 1'b0;
    endtask

    task automatic model_add(input logic [N-1:0] mc);
        acc_m[2*N:N] = {1'b0, acc_m[2*N-1:N]} + {1'b0, mc};
    endtask

    task automatic model_shift();
        acc_m = acc_m >> 1;
    endtask

    task automatic run_mult(input logic [N-1:0] mc, input logic [N-1:0] mp,
                            input logic [2*N-1:0] exp_p, input bit combined);
        Load = 1'b1; Mcand = mc; Mplier = mp;
        tick();
        acc_m = {(N+1)'(0), mp};
        carry_seen = 1'b0;
        chk("load_acc", 32'(dut.acc_q), 32'(acc_m));
        chk("load_valid", 32'(Valid), 32'(0));
        for (int i = 0; i < N; i++) begin
            chk("m_bit", 32'(M), 32'(mp[i]));
            chk("k_flag", 32'(K), 32'(i == N-1));
            if (combined) begin
                Ad = mp[i]; Sh = 1'b1;
                tick();
                if (mp[i]) model_add(mc);
                model_shift();
            end else begin
                if (mp[i]) begin
                    Ad = 1'b1;
                    tick();
                    model_add(mc);
                    chk("add_acc", 32'(dut.acc_q), 32'(acc_m));
                    if (dut.acc_q[2*N]) carry_seen = 1'b1;
                end
                Sh = 1'b1;
                tick();
                model_shift();
            end
            chk("step_acc", 32'(dut.acc_q), 32'(acc_m));
        end
        chk("end_k", 32'(K), 32'(0));
        chk("end_cnt", 32'(dut.cnt_q), 32'(0));
        chk("end_carry", 32'(dut.acc_q[2*N]), 32'(0));
        Done = 1'b1;
        chk("pre_done_valid", 32'(Valid), 32'(0));
        tick();
        chk("valid", 32'(Valid), 32'(1));
        chk("product", 32'(Product), 32'(exp_p));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        Rst_n = 1'b0;
        Load = 1'b0; Ad = 1'b0; Sh = 1'b0; Done = 1'b0;
        Mcand = '0; Mplier = '0;
        acc_m = '0;
        carry_seen = 1'b0;

        #1;
        chk("rst_m", 32'(M), 32'(0));
        chk("rst_k", 32'(K), 32'(0));
        chk("rst_product", 32'(Product), 32'(0));
        chk("rst_valid", 32'(Valid), 32'(0));
        chk("rst_acc", 32'(dut.acc_q), 32'(0));
        @(negedge Clk);
        Rst_n = 1'b1;

        // 13 x 11, separate Ad and Sh cycles.
        run_mult(4'd13, 4'd11, 8'h8F, 1'b0);

        // 15 x 15 exercises the adder carry.
        run_mult(4'd15, 4'd15, 8'hE1, 1'b0);
        chk("carry_seen", 32'(carry_seen), 32'(1));

        // 9 x 0: shifts only.
        run_mult(4'd9, 4'd0, 8'h00, 1'b0);

        // Load wins over Ad and Sh.
        Load = 1'b1; Ad = 1'b1; Sh = 1'b1; Mcand = 4'd5; Mplier = 4'd3;
        tick();
        chk("ld_prio_acc", 32'(dut.acc_q), 32'h003);
        chk("ld_prio_cnt", 32'(dut.cnt_q), 32'(0));
        Ad = 1'b1; Sh = 1'b1;
        tick();
        chk("adsh_acc", 32'(dut.acc_q), 32'h029);
        chk("adsh_cnt", 32'(dut.cnt_q), 32'(1));

        // Combined Ad+Sh throughout a full multiply.
        run_mult(4'd13, 4'd11, 8'h8F, 1'b1);

        // Asynchronous reset between two shifts.
        Load = 1'b1; Mcand = 4'd13; Mplier = 4'd11;
        tick();
        Sh = 1'b1;
        tick();
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst_acc", 32'(dut.acc_q), 32'(0));
        chk("arst_cnt", 32'(dut.cnt_q), 32'(0));
        chk("arst_product", 32'(Product), 32'(0));
        chk("arst_valid", 32'(Valid), 32'(0));
        chk("arst_m", 32'(M), 32'(0));
        @(negedge Clk);
        Rst_n = 1'b1;
        run_mult(4'd6, 4'd7, 8'd42, 1'b0);

        // Idle hold after Done.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_product", 32'(Product), 32'd42);
            chk("hold_valid", 32'(Valid), 32'(1));
        end
        Load = 1'b1; Mcand = 4'd2; Mplier = 4'd3;
        tick();
        chk("reload_valid", 32'(Valid), 32'(0));
        chk("reload_product", 32'(Product), 32'd42);

        // Done with Load: product takes pre-Load ACC, Valid cleared.
        Sh = 1'b1;
        tick();
        Done = 1'b1; Load = 1'b1; Mcand = 4'd1; Mplier = 4'd1;
        tick();
        chk("done_ld_product", 32'(Product), 32'h01);
        chk("done_ld_valid", 32'(Valid), 32'(0));
        chk("done_ld_acc", 32'(dut.acc_q), 32'h001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
